// File: rtl/dram_acc_pkg.sv
// Shared encodings for the byte-path DRAM access controller (dram_access_ctrl).
// Optional build macro DRAM_ACC_MISALIGN_EN is consumed by dram_acc_lane.
package dram_acc_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   // The DRAM data select value that routes its byte read/write path.
   localparam logic [1:0] MEM_SEL_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/dram_acc_lane.sv
// Byte-count decode, legality check and load extension for dram_access_ctrl.
// Define DRAM_ACC_MISALIGN_EN to allow misaligned halves/words (sequenced byte by byte).
module dram_acc_lane
   import dram_acc_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] raw_i,
   output logic [2:0]  nbytes_o,
   output logic        err_o,
   output logic [31:0] ext_o
);

`ifdef DRAM_ACC_MISALIGN_EN
   localparam bit ALLOW_MISALIGN = 1'b1;
`else
   localparam bit ALLOW_MISALIGN = 1'b0;
`endif

   logic misaligned;

   // raw_i holds the loaded bytes right-aligned, lowest address in the most significant loaded byte.
   always_comb begin
      nbytes_o   = 3'd0;
      misaligned = 1'b0;
      ext_o      = raw_i;
      case (size_i)
         SIZE_BYTE: begin
            nbytes_o = 3'd1;
            ext_o    = {{24{raw_i[7] & ~unsigned_i}}, raw_i[7:0]};
         end
         SIZE_HALF: begin
            nbytes_o   = 3'd2;
            misaligned = addr_lo_i[0];
            ext_o      = {{16{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
         end
         SIZE_WORD: begin
            nbytes_o   = 3'd4;
            misaligned = |addr_lo_i;
            ext_o      = raw_i;
         end
         default: begin
            nbytes_o = 3'd0;
         end
      endcase
      err_o = (size_i == SIZE_ILLEGAL) || (misaligned && !ALLOW_MISALIGN);
   end

endmodule

// File: rtl/dram_access_ctrl.sv
// Core-side load/store sequencer issuing one DRAM byte access per cycle, big-endian.
// Build option DRAM_ACC_MISALIGN_EN (see dram_acc_lane) makes misaligned accesses legal.
module dram_access_ctrl
   import dram_acc_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [1:0]        mem_sel_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        size_q, size_d;
   logic              we_q, we_d;
   logic              uns_q, uns_d;
   logic              err_q, err_d;

   logic [1:0]        laneSize;
   logic [1:0]        laneAddrLo;
   logic [2:0]        nbytes;
   logic              laneErr;
   logic [31:0]       laneExt;
   logic              issue;

   // In IDLE the lane judges the incoming request; afterwards it serves the latched one.
   assign laneSize   = (state_q == IDLE) ? req_size_i      : size_q;
   assign laneAddrLo = (state_q == IDLE) ? req_addr_i[1:0] : addr_q[1:0];

   dram_acc_lane u_lane (
      .size_i     (laneSize),
      .addr_lo_i  (laneAddrLo),
      .unsigned_i (uns_q),
      .raw_i      (data_q),
      .nbytes_o   (nbytes),
      .err_o      (laneErr),
      .ext_o      (laneExt)
   );

   assign issue = (state_q == XFER) && (cnt_q < nbytes);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         size_q  <= SIZE_BYTE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
      end
   end

   // cnt_q walks the issue index; loads stay one extra cycle (cnt_q == nbytes) to catch the last byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               size_d = req_size_i;
               we_d   = req_we_i;
               uns_d  = req_unsigned_i;
               err_d  = laneErr;
               cnt_d  = 3'd0;
               data_d = 32'd0;
               if (laneErr) begin
                  state_d = RESP;
               end else begin
                  addr_d = req_addr_i;
                  case (req_size_i)
                     SIZE_BYTE: wdata_d = {req_wdata_i[7:0], 24'd0};
                     SIZE_HALF: wdata_d = {req_wdata_i[15:0], 16'd0};
                     default:   wdata_d = req_wdata_i;
                  endcase
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            if (!we_q && (cnt_q != 3'd0)) begin
               data_d = {data_q[23:0], mem_rdata_i};
            end
            if (issue) begin
               wdata_d = {wdata_q[23:0], 8'd0};
               if ((cnt_q + 3'd1) < nbytes) begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
            if (we_q ? (cnt_q == (nbytes - 3'd1)) : (cnt_q == nbytes)) begin
               state_d = RESP;
            end
            cnt_d = cnt_q + 3'd1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset gates the handshake and DRAM strobe so nothing is accepted or written while it is held.
   always_comb begin
      req_ready_o = !rst_i && (state_q == IDLE);
      rsp_valid_o = !rst_i && (state_q == RESP);
      rsp_err_o   = rsp_valid_o && err_q;
      rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? laneExt : 32'd0;
      mem_we_o    = !rst_i && issue && we_q;
      mem_wdata_o = mem_we_o ? wdata_q[31:24] : 8'd0;
      mem_addr_o  = addr_q;
      mem_sel_o   = MEM_SEL_BYTE;
   end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Self-checking bench for dram_access_ctrl against a byte-array reference model.
// Honors DRAM_ACC_MISALIGN_EN the same way as the design build.
module tb_dram_access_ctrl;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [9:0]  addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqWe = 1'b0;
   logic [1:0]  reqSize = 2'b00;
   logic        reqUns = 1'b0;
   logic [9:0]  reqAddr = 10'd0;
   logic [31:0] reqWdata = 32'd0;
   logic        reqReady;
   logic        rspValid;
   logic [31:0] rspRdata;
   logic        rspErr;
   logic [9:0]  memAddr;
   logic [1:0]  memSel;
   logic        memWe;
   logic [7:0]  memWdata;
   logic [7:0]  memRdata;

   logic [7:0]  dram   [0:1023];
   logic [7:0]  seed   [0:1023];
   logic [7:0]  refMem [0:1023];
   logic        loadSeed = 1'b1;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   dram_access_ctrl #(.ADDR_W(10)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (reqValid),
      .req_ready_o    (reqReady),
      .req_we_i       (reqWe),
      .req_size_i     (reqSize),
      .req_unsigned_i (reqUns),
      .req_addr_i     (reqAddr),
      .req_wdata_i    (reqWdata),
      .rsp_valid_o    (rspValid),
      .rsp_rdata_o    (rspRdata),
      .rsp_err_o      (rspErr),
      .mem_addr_o     (memAddr),
      .mem_sel_o      (memSel),
      .mem_we_o       (memWe),
      .mem_wdata_o    (memWdata),
      .mem_rdata_i    (memRdata)
   );

   // Byte-wide DRAM with a registered read port.
   always @(posedge clk) begin
      if (loadSeed) begin
         for (int i = 0; i < 1024; i++) dram[i] <= seed[i];
      end else if (memWe === 1'b1) begin
         dram[memAddr] <= memWdata;
      end
      memRdata <= dram[memAddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   function automatic int refBytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit refIsErr(input logic [1:0] size, input logic [9:0] addr);
      if (size == 2'b11) return 1'b1;
`ifdef DRAM_ACC_MISALIGN_EN
      return 1'b0;
`else
      return (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`endif
   endfunction

   function automatic logic [31:0] refLoad(input req_t r);
      logic [31:0] v = 32'd0;
      int n = refBytes(r.size);
      int bits = 8 * n;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(refMem[(int'(r.addr) + i) % 1024]);
      if (!r.uns && n < 4 && v[bits-1]) v = v | ~((32'd1 << bits) - 32'd1);
      return v;
   endfunction

   task automatic refStore(input req_t r);
      int n = refBytes(r.size);
      for (int i = 0; i < n; i++)
         refMem[(int'(r.addr) + i) % 1024] = 8'((r.wdata >> (8 * (n - 1 - i))) & 32'hFF);
   endtask

   function automatic req_t randReq();
      req_t r;
      int s = $urandom_range(0, 7);
      r.size  = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
      r.we    = 1'($urandom_range(0, 1));
      r.uns   = 1'($urandom_range(0, 1));
      r.wdata = $urandom();
      r.addr  = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
         if (r.size == 2'b01) r.addr[0] = 1'b0;
         else if (r.size == 2'b10) r.addr[1:0] = 2'b00;
      end
      return r;
   endfunction

   // Presents r, waits for acceptance, optionally holds nxt on the bus, then checks the whole transfer.
   task automatic applyStimulus(input string tag, input req_t r, input bit haveNext, input req_t nxt, output int waited);
      int n, k, weCnt, addrBad, expLat;
      bit isErr, got;
      logic [31:0] expRd, rdSeen, errSeen;
      reqValid = 1'b1; reqWe = r.we; reqSize = r.size; reqUns = r.uns; reqAddr = r.addr; reqWdata = r.wdata;
      waited = 0;
      while (reqReady !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (reqReady !== 1'b1) begin
         checkOutput({tag, " ready timeout"}, 32'd0, 32'd1);
         reqValid = 1'b0;
         return;
      end
      isErr  = refIsErr(r.size, r.addr);
      n      = refBytes(r.size);
      expRd  = (isErr || r.we) ? 32'd0 : refLoad(r);
      expLat = isErr ? 1 : (r.we ? n + 1 : n + 2);
      @(negedge clk);
      if (haveNext) begin
         reqWe = nxt.we; reqSize = nxt.size; reqUns = nxt.uns; reqAddr = nxt.addr; reqWdata = nxt.wdata;
      end else begin
         reqValid = 1'b0;
      end
      k = 1; got = 1'b0; weCnt = 0; addrBad = 0; rdSeen = 32'd0; errSeen = 32'd0;
      while (!got && k <= 20) begin
         if (!isErr && k <= n && memAddr !== 10'((int'(r.addr) + k - 1) % 1024)) addrBad++;
         if (memWe === 1'b1) weCnt++;
         if (rspValid === 1'b1) begin
            got = 1'b1;
            rdSeen = rspRdata;
            errSeen = {31'd0, rspErr};
         end else begin
            @(negedge clk);
            k++;
         end
      end
      checkOutput({tag, " latency"}, got ? k : 99, expLat);
      checkOutput({tag, " err"}, errSeen, {31'd0, isErr});
      checkOutput({tag, " rdata"}, rdSeen, expRd);
      checkOutput({tag, " mem writes"}, weCnt, (r.we && !isErr) ? n : 0);
      if (!isErr) checkOutput({tag, " addr seq"}, addrBad, 0);
      if (r.we && !isErr) refStore(r);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      req_t cur, nxt, none;
      int waited, mism;
      logic sawRsp;
      none = '0;
      for (int i = 0; i < 1024; i++) begin
         seed[i]   = 8'($urandom);
         refMem[i] = seed[i];
      end

      repeat (3) @(negedge clk);
      checkOutput("reset ready", {31'd0, reqReady}, 32'd0);
      checkOutput("reset rsp valid", {31'd0, rspValid}, 32'd0);
      checkOutput("reset mem we", {31'd0, memWe}, 32'd0);
      rst = 1'b0;
      loadSeed = 1'b0;
      @(negedge clk);
      checkOutput("post reset ready", {31'd0, reqReady}, 32'd1);
      checkOutput("post reset mem addr", {22'd0, memAddr}, 32'd0);
      checkOutput("post reset mem wdata", {24'd0, memWdata}, 32'd0);
      checkOutput("post reset mem sel", {30'd0, memSel}, 32'd2);
      checkOutput("post reset rsp rdata", rspRdata, 32'd0);
      checkOutput("post reset rsp err", {31'd0, rspErr}, 32'd0);

      applyStimulus("word store", '{we:1'b1, size:2'b10, uns:1'b0, addr:10'h010, wdata:32'h12345678}, 1'b0, none, waited);
      checkOutput("dram 0x10", {24'd0, dram[10'h010]}, 32'h12);
      checkOutput("dram 0x13", {24'd0, dram[10'h013]}, 32'h78);
      applyStimulus("word load", '{we:1'b0, size:2'b10, uns:1'b0, addr:10'h010, wdata:32'd0}, 1'b0, none, waited);

      applyStimulus("byte store", '{we:1'b1, size:2'b00, uns:1'b0, addr:10'h020, wdata:32'h00000080}, 1'b0, none, waited);
      applyStimulus("byte load s", '{we:1'b0, size:2'b00, uns:1'b0, addr:10'h020, wdata:32'd0}, 1'b0, none, waited);
      applyStimulus("byte load u", '{we:1'b0, size:2'b00, uns:1'b1, addr:10'h020, wdata:32'd0}, 1'b0, none, waited);

      applyStimulus("half store", '{we:1'b1, size:2'b01, uns:1'b0, addr:10'h030, wdata:32'h0000F001}, 1'b0, none, waited);
      applyStimulus("half load s", '{we:1'b0, size:2'b01, uns:1'b0, addr:10'h030, wdata:32'd0}, 1'b0, none, waited);
      applyStimulus("half load u", '{we:1'b0, size:2'b01, uns:1'b1, addr:10'h030, wdata:32'd0}, 1'b0, none, waited);

`ifdef DRAM_ACC_MISALIGN_EN
      applyStimulus("wrap store", '{we:1'b1, size:2'b10, uns:1'b0, addr:10'h3FE, wdata:32'hCAFEF00D}, 1'b0, none, waited);
      checkOutput("dram 0x000", {24'd0, dram[10'h000]}, 32'hF0);
      applyStimulus("wrap load", '{we:1'b0, size:2'b10, uns:1'b0, addr:10'h3FE, wdata:32'd0}, 1'b0, none, waited);
`else
      applyStimulus("misaligned word", '{we:1'b0, size:2'b10, uns:1'b0, addr:10'h011, wdata:32'd0}, 1'b0, none, waited);
      applyStimulus("misaligned half", '{we:1'b1, size:2'b01, uns:1'b0, addr:10'h031, wdata:32'h0000BEEF}, 1'b0, none, waited);
`endif
      applyStimulus("illegal size", '{we:1'b1, size:2'b11, uns:1'b0, addr:10'h000, wdata:32'h55555555}, 1'b0, none, waited);

      // Reset in the second cycle of a word store leaves only the first byte written.
      applyStimulus("clear store", '{we:1'b1, size:2'b10, uns:1'b0, addr:10'h040, wdata:32'd0}, 1'b0, none, waited);
      reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'b10; reqUns = 1'b0; reqAddr = 10'h040; reqWdata = 32'hAABBCCDD;
      waited = 0;
      while (reqReady !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("abort accept", {31'd0, reqReady}, 32'd1);
      @(negedge clk);
      reqValid = 1'b0;
      sawRsp = rspValid;
      @(negedge clk);
      sawRsp = sawRsp | rspValid;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort ready in reset", {31'd0, reqReady}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      sawRsp = sawRsp | rspValid;
      checkOutput("abort ready after", {31'd0, reqReady}, 32'd1);
      checkOutput("abort no response", {31'd0, sawRsp}, 32'd0);
      checkOutput("abort dram 0x40", {24'd0, dram[10'h040]}, 32'hAA);
      checkOutput("abort dram 0x41", {24'd0, dram[10'h041]}, 32'h00);
      checkOutput("abort dram 0x43", {24'd0, dram[10'h043]}, 32'h00);
      refMem[10'h040] = 8'hAA;

      cur = randReq();
      for (int i = 0; i < 100; i++) begin
         nxt = randReq();
         applyStimulus($sformatf("rand%0d", i), cur, i < 99, nxt, waited);
         if (i > 0) checkOutput($sformatf("rand%0d reaccept", i), waited, 1);
         cur = nxt;
      end

      @(negedge clk);
      mism = 0;
      for (int i = 0; i < 1024; i++) if (dram[i] !== refMem[i]) mism++;
      checkOutput("final memory", mism, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
